// File: rtl/inv_key_stream.sv
// inv_key_stream
//   Walks an AES-128 key schedule backwards. A final (round-10) round key
//   is accepted on the input handshake. The block then emits round keys
//   10, 9, ..., 0, one per output handshake, with no bubbles.
//
// Ports
//   clk       in   1    clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   in_valid  in   1    in_key holds a round-10 key
//   in_ready  out  1    block can accept in_key (IDLE, out of reset)
//   in_key    in   128  round-10 key, word 0 in bits 127:96
//   rk_valid  out  1    rk_key/rk_round valid
//   rk_ready  in   1    consumer takes rk_key
//   rk_key    out  128  round key, same ordering as in_key
//   rk_round  out  4    round index of rk_key, 10 down to 0
//   rk_last   out  1    rk_valid and rk_round == 0
//   busy      out  1    a sequence is being emitted
//   replay    in   1    only with INV_KEY_STORE_EN: re-emit the stored sequence
//
// Option macro INV_KEY_STORE_EN
//   When it is defined, an 11 x 128-bit store keeps every emitted key.
//   The replay input restarts emission from that store once a full
//   sequence has completed. If in_valid and replay are both high,
//   in_valid has priority.
module inv_key_stream (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_key,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_key,
   output logic [3:0]   rk_round,
   output logic         rk_last,
   output logic         busy
`ifdef INV_KEY_STORE_EN
   ,
   input  logic         replay
`endif
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t         state_q, state_d;
   logic           armed_q;
   logic [127:0]   key_q, key_d;
   logic [3:0]     round_q, round_d;
   logic [127:0]   prev_key;
   logic           accept_in;
   logic           out_hs;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // AES S-box. The high nibble is the first argument.
   // The inverse is x^254 = x^2 * x^4 * ... * x^128, which maps 0 to 0.
   // The AES affine transform is applied after it.
   function automatic logic [7:0] sbox(input logic [3:0] hi, input logic [3:0] lo);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = {hi, lo};
      inv = 8'h01;
      repeat (7) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Inverse key expansion: derive the round-1 key from the current key
   always_comb begin
      logic [31:0] c0, c1, c2, c3, p0, p1, p2, p3, rot, sub;
      c0 = key_q[127:96];
      c1 = key_q[95:64];
      c2 = key_q[63:32];
      c3 = key_q[31:0];
      p3 = c3 ^ c2;
      p2 = c2 ^ c1;
      p1 = c1 ^ c0;
      rot = {p3[23:0], p3[31:24]};
      sub = {sbox(rot[31:28], rot[27:24]), sbox(rot[23:20], rot[19:16]),
             sbox(rot[15:12], rot[11:8]),  sbox(rot[7:4],   rot[3:0])};
      p0 = c0 ^ sub ^ {rcon(round_q), 24'h0};
      prev_key = {p0, p1, p2, p3};
   end

`ifdef INV_KEY_STORE_EN
   logic [127:0] store_q [0:10];
   logic         store_vld_q;
   logic         start_replay;

   // Store contents need no reset: they are only read while store_vld_q is set
   always_ff @(posedge clk) begin
      if (out_hs) store_q[round_q] <= key_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      store_vld_q <= 1'b0;
      else if (out_hs && round_q == 0) store_vld_q <= 1'b1;
   end

   assign start_replay = (state_q == IDLE) && armed_q && !in_valid && replay && store_vld_q;
`endif

   assign accept_in = (state_q == IDLE) && armed_q && in_valid;
   assign out_hs    = (state_q == EMIT) && rk_ready;

   // State and datapath registers
   // armed_q holds in_ready low until the first edge after reset is released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
         key_q   <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         key_q   <= key_d;
         round_q <= round_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      case (state_q)
         IDLE: begin
            if (accept_in) begin
               state_d = EMIT;
               key_d   = in_key;
               round_d = 4'd10;
            end
`ifdef INV_KEY_STORE_EN
            else if (start_replay) begin
               state_d = EMIT;
               key_d   = store_q[10];
               round_d = 4'd10;
            end
`endif
         end
         EMIT: begin
            if (out_hs) begin
               if (round_q == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  key_d   = prev_key;
                  round_d = round_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready = (state_q == IDLE) && armed_q;
      rk_valid = (state_q == EMIT);
      busy     = (state_q == EMIT);
      rk_last  = (state_q == EMIT) && (round_q == 4'd0);
      rk_key   = key_q;
      rk_round = round_q;
   end

endmodule

// File: tb/tb_inv_key_stream.sv
// Testbench for inv_key_stream: FIPS-197 vector table, randomized keys
// checked against a forward key-expansion model, and reset/back-to-back
// corner sequences.
module tb_inv_key_stream;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_key = '0;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic [127:0] rk_key;
   logic [3:0]   rk_round;
   logic         rk_last;
   logic         busy;
`ifdef INV_KEY_STORE_EN
   logic         replay = 1'b0;
`endif

   inv_key_stream dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_key(in_key), .rk_valid(rk_valid), .rk_ready(rk_ready),
      .rk_key(rk_key), .rk_round(rk_round), .rk_last(rk_last), .busy(busy)
`ifdef INV_KEY_STORE_EN
      , .replay(replay)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Standard AES S-box table
   logic [0:2047] sbt = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] ref_sb(input logic [7:0] x);
      int i;
      i = int'(x);
      return sbt[i*8 +: 8];
   endfunction

   // Reference: forward AES-128 key expansion from round-0 key
   logic [127:0] exp_rk [0:10];

   task automatic expand(input logic [127:0] k0);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {ref_sb(t[23:16]), ref_sb(t[15:8]), ref_sb(t[7:0]), ref_sb(t[31:24])} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic send(input logic [127:0] k);
      int b;
      b = 0;
      while (!in_ready && b < 50) begin
         @(posedge clk); #1;
         b++;
      end
      chk("in_ready_wait", {127'b0, in_ready}, 128'd1);
      in_valid = 1'b1;
      in_key   = k;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Checks one emitted sequence against exp_rk. Called #1 after the edge
   // on which the sequence was started.
   task automatic run_stream(input bit rnd_ready, input int ignore_at, output int cycles);
      int idx;
      int budget;
      bit rdy;
      idx = 10;
      budget = 400;
      cycles = 0;
      while (idx >= 0 && budget > 0) begin
         chk("emit_valid", {127'b0, rk_valid}, 128'd1);
         chk("emit_busy_ready", {126'b0, busy, in_ready}, 128'd2);
         chk("emit_round", {124'b0, rk_round}, 128'(idx));
         chk("emit_key", rk_key, exp_rk[idx]);
         chk("emit_last", {127'b0, rk_last}, (idx == 0) ? 128'd1 : 128'd0);
         rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         rk_ready = rdy;
         if (cycles == ignore_at) begin
            in_valid = 1'b1;
            in_key   = ~exp_rk[10];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (rdy) idx--;
         cycles++;
         budget--;
      end
      in_valid = 1'b0;
      chk("stream_budget", 128'(budget > 0), 128'd1);
      chk("after_round0", {126'b0, rk_valid, in_ready}, 128'd1);
   endtask

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] key;
      logic         last;
   } vec_t;

   vec_t fips [0:10];

   task automatic fips_table();
      for (int i = 0; i < 11; i++) begin
         chk("fips_valid", {127'b0, rk_valid}, 128'd1);
         chk("fips_round", {124'b0, rk_round}, {124'b0, fips[i].rnd});
         chk("fips_key", rk_key, fips[i].key);
         chk("fips_last", {127'b0, rk_last}, {127'b0, fips[i].last});
         rk_ready = 1'b1;
         @(posedge clk); #1;
      end
      chk("fips_done", {126'b0, rk_valid, in_ready}, 128'd1);
   endtask

   initial begin
      int cyc;
      int b;
      logic [127:0] k;

      fips[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
      fips[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
      fips[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b0};
      fips[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0};
      fips[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0};
      fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0};
      fips[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b0};
      fips[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0};
      fips[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
      fips[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
      fips[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};

      // Reset state
      #12;
      chk("rst_ctrl", {124'b0, rk_valid, rk_last, busy, in_ready}, 128'd0);
      chk("rst_key", rk_key, 128'd0);
      chk("rst_round", {124'b0, rk_round}, 128'd0);
      rk_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("rel_before_edge", {127'b0, in_ready}, 128'd0);
      @(posedge clk); #1;
      chk("rel_after_edge", {125'b0, in_ready, busy, rk_valid}, 128'd4);

`ifdef INV_KEY_STORE_EN
      replay = 1'b1;
      @(posedge clk); #1;
      replay = 1'b0;
      chk("replay_empty", {126'b0, busy, rk_valid}, 128'd0);
`endif

      // FIPS-197 vector
      send(fips[0].key);
      fips_table();

`ifdef INV_KEY_STORE_EN
      replay = 1'b1;
      @(posedge clk); #1;
      replay = 1'b0;
      fips_table();
`endif

      // Randomized keys with backpressure and ignored in_valid
      for (int t = 0; t < 6; t++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         expand(k);
         send(exp_rk[10]);
         run_stream(1'b1, 2 + t, cyc);
      end

      // Full rate: 11 cycles, then back-to-back acceptance
      expand({$urandom, $urandom, $urandom, $urandom});
      send(exp_rk[10]);
      run_stream(1'b0, -1, cyc);
      chk("full_rate_cycles", 128'(cyc), 128'd11);
      expand({$urandom, $urandom, $urandom, $urandom});
      in_valid = 1'b1;
      in_key   = exp_rk[10];
      @(posedge clk); #1;
      in_valid = 1'b0;
      run_stream(1'b0, -1, cyc);
      chk("b2b_cycles", 128'(cyc), 128'd11);

      // Reset mid-sequence at round 5
      expand({$urandom, $urandom, $urandom, $urandom});
      send(exp_rk[10]);
      rk_ready = 1'b1;
      b = 0;
      while (rk_round != 4'd5 && b < 20) begin
         @(posedge clk); #1;
         b++;
      end
      chk("reach_round5", {124'b0, rk_round}, 128'd5);
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {124'b0, rk_valid, rk_last, busy, in_ready}, 128'd0);
      chk("midrst_key", rk_key, 128'd0);
      chk("midrst_round", {124'b0, rk_round}, 128'd0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("midrst_rel_pre", {127'b0, in_ready}, 128'd0);
      @(posedge clk); #1;
      chk("midrst_no_resume", {125'b0, in_ready, busy, rk_valid}, 128'd4);
      expand({$urandom, $urandom, $urandom, $urandom});
      send(exp_rk[10]);
      run_stream(1'b1, 4, cyc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 required less");
      $fatal(1);
   end

endmodule

// File: doc/inv_key_stream.md
INV_KEY_STREAM -- requirements
Module: inv_key_stream

Interface
REQ-001 The block SHALL have no parameters; every width is fixed: 128-bit keys, 4-bit round index.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_key holds a final (round-10) AES-128 round key.
REQ-005 in_ready  output  1  block can accept in_key.
REQ-006 in_key  input  128  round-10 key, bit 0 = MSB; word j = bits 32j..32j+31.
REQ-007 rk_valid  output  1  rk_key/rk_round hold a valid round key.
REQ-008 rk_ready  input  1  consumer accepts the current rk_key.
REQ-009 rk_key  output  128  round key, same bit/word ordering as in_key.
REQ-010 rk_round  output  4  round index of rk_key, 10 down to 0.
REQ-011 rk_last  output  1  high when rk_valid=1 and rk_round=0.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 States SHALL be IDLE and EMIT. in_ready=1 only in IDLE; busy=1 only in EMIT.
REQ-014 The input handshake occurs on a clock edge where in_valid=1 and in_ready=1. On that edge the block registers in_key as the current key, sets round to 10 and enters EMIT.
REQ-015 In EMIT, rk_valid SHALL be 1. rk_key and rk_round SHALL stay stable until the output handshake (rk_valid=1 and rk_ready=1).
REQ-016 On an output handshake with round>0, the next cycle SHALL present round-1 and its key. This gives a sustained rate of one key per cycle with no bubbles.
REQ-017 Previous key from current words c0..c3:
- p3 = c3^c2
- p2 = c2^c1
- p1 = c1^c0
- p0 = c0 ^ SubWord(RotWord(p3)) ^ Rcon(round)
REQ-018 RotWord SHALL rotate left by one byte. SubWord SHALL apply the team's existing sbox module to each byte, with the high nibble on the first input.
REQ-019 Rcon(r) SHALL be {rc,24'h0}, with rc = 01,02,04,08,10,20,40,80,1b,36 for r = 1..10.
REQ-020 On the output handshake with round=0, the block SHALL return to IDLE. rk_valid SHALL fall and in_ready SHALL rise on the next cycle.
REQ-021 Input latency: the round-10 key SHALL appear with rk_valid=1 one cycle after the input handshake.
REQ-022 With rk_ready held at 1, the full sequence SHALL take 11 consecutive cycles.
REQ-023 in_valid while busy SHALL be ignored and cannot corrupt the current sequence.
REQ-024 rk_ready while rk_valid=0 SHALL have no effect.

Reset
REQ-025 Asserting rst_n=0 SHALL take effect immediately, at any time including mid-sequence. Resulting values:
- state = IDLE
- rk_valid = 0, rk_last = 0, busy = 0
- rk_key = 0, rk_round = 0
- in_ready = 0 while rst_n=0
REQ-026 in_ready SHALL be 1 from the first clock edge after rst_n deasserts. A sequence interrupted by reset SHALL NOT resume.

Configuration
REQ-027 Macro INV_KEY_STORE_EN SHALL control replay support.
- Defined: an 11-entry x 128-bit store captures every emitted key, indexed by round.
- Defined: a 1-bit input replay is added. replay=1 in IDLE, after at least one complete sequence, starts EMIT from the store (rounds 10..0, identical timing) without in_key.
- Defined: if replay and in_valid are both high in IDLE, in_valid wins and the store is overwritten as new keys emit.
- Defined: reset clears the store's valid flag.
- Not defined: the replay port and store are absent; behaviour is exactly REQ-013..026.

Verification
REQ-028 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: in_key = d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> round 10 = in_key; round 9 = ac7766f319fadc2128d12941575c006e; round 0 = 2b7e151628aed2a6abf7158809cf4f3c with rk_last=1; 11 cycles total.
REQ-029 Backpressure: rk_ready toggled pseudo-randomly -> rk_key/rk_round stable while stalled; same 11 keys in order; no key skipped or duplicated.
REQ-030 rst_n pulsed low at rk_round=5 -> outputs zero immediately; in_ready=1 after release; a new in_key emits a fresh round 10.
REQ-031 in_valid pulsed with a different key during EMIT -> ignored; original sequence completes unchanged.
REQ-032 Back-to-back: a second in_valid asserted in the cycle in_ready rises after round 0 -> accepted; round 10 appears one cycle later.
REQ-033 With INV_KEY_STORE_EN defined: replay after the REQ-028 sequence -> identical 11 keys; replay before any sequence -> ignored.
